pipe_fetch_queue: RTL and testbench
===================================

# pipe_fetch_queue

Instruction prefetch queue between a variable-latency instruction memory and the IF/ID pipeline register. It generates sequential fetch addresses, runs a one-outstanding-request handshake with instruction memory, and buffers up to DEPTH fetched words with their PC and PC+4. It presents the head entry to the IF/ID register, and flushes and re-steers on branch or jump redirects from the ID stage.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clock  in  1  single clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- redirect  in  1  ID stage taken branch/jump/jr; flush and re-steer
- redirect_pc  in  32  new fetch address, valid with redirect
- deq  in  1  IF/ID register accepts head entry (pipeline nostall)
- out_valid  out  1  head entry valid
- out_pc  out  32  PC of head instruction
- out_pc_plus_4  out  32  out_pc + 4
- out_inst  out  32  head instruction word
- imem_req  out  1  request to instruction memory
- imem_addr  out  32  word-aligned request address
- imem_ack  in  1  memory returns data this cycle (only while imem_req=1)
- imem_rdata  in  32  instruction data, valid with imem_ack

## Operation
- States: IDLE (no request), WAIT (request outstanding, data kept), DISCARD (request outstanding, data dropped).
- imem_req = (state != IDLE); imem_addr = registered req_pc, stable while imem_req=1.
- fetch_pc: reset to RESET_PC; +4 on each kept ack; loaded with redirect_pc on redirect. Bits [1:0] forced to 0.
- deq_fire = deq & out_valid; deq with out_valid=0 is ignored.
- next_count = count + kept_ack - deq_fire.
- IDLE -> WAIT when next_count < DEPTH; req_pc <= fetch_pc.
- WAIT with ack: write {fetch_pc, fetch_pc+4, imem_rdata} at tail. Stay in WAIT with req_pc <= fetch_pc+4 if next_count < DEPTH, else go to IDLE.
- WAIT without ack: hold.
- Redirect has priority over everything:
  - count <= 0 and deq ignored.
  - fetch_pc <= redirect_pc.
  - Redirect in WAIT with no ack: go to DISCARD. The request stays high with the old address until ack; that data is dropped, then the block goes to WAIT at the redirect address.
  - Redirect in WAIT with ack the same cycle: drop the data and go to WAIT with req_pc <= redirect_pc.
  - Redirect in IDLE: go to WAIT with req_pc <= redirect_pc.
  - Redirect in DISCARD: update fetch_pc only and stay in DISCARD.
- When out_valid=0, out_pc, out_pc_plus_4 and out_inst drive 0.
- Queue never overflows, because a request is issued only when a slot is reserved. Pointers wrap modulo DEPTH.

## Timing
- Reset values: state IDLE, count 0, fetch_pc RESET_PC, imem_req 0, imem_addr 0, out_valid 0, all data outputs 0.
- Reset assertion mid-operation immediately clears everything. Any ack arriving during reset is ignored.
- imem_req first rises one cycle after resetn is released.
- Zero-wait memory (ack in the same cycle as req) sustains one fetch per cycle.
- Ack-to-out_valid latency is 1 cycle (entry registered).
- Redirect-to-imem_req at the new address:
  - 1 cycle from IDLE or WAIT+ack.
  - 1 cycle after the discarded ack otherwise.

## Configuration
- PIPE_FETCH_BYPASS_EN defined: if the queue is empty and a kept ack arrives, out_valid, out_pc and out_inst reflect imem_rdata combinationally in that cycle. deq_fire in that cycle consumes the word without writing it. This gives 0-cycle ack-to-out latency.
- Not defined: strictly registered outputs with 1-cycle latency as above.

## Structure
- Shared package pipe_fetch_pkg holds:
  - state enum {IDLE, WAIT, DISCARD}
  - INST_W=32 and ADDR_W=32
  - NOP_INST=32'h0000_0000
  - entry typedef {pc, pc_plus_4, inst}
- One sub-module, fetch_queue_fifo, with parameter DEPTH. It provides push, pop, flush, head entry, and count; it contains the pointers and storage.
- The top module holds the FSM, fetch_pc, and handshake.

## Test plan
- Reset, zero-wait memory, deq=1 constant:
  - imem_addr is 0, 4, 8, ... on consecutive cycles.
  - out_pc follows one cycle behind, with out_pc_plus_4 = out_pc+4.
- deq=0, DEPTH=4, zero-wait:
  - exactly 4 acks are accepted, then imem_req=0.
  - one deq pulse produces exactly one new request at 0x10.
- Memory with 3-cycle ack latency; redirect to 0x100 in cycle 1 of the wait:
  - the old-address data is discarded and never appears on out.
  - the next imem_addr is 0x100 and the first out_pc is 0x100.
- Redirect to 0x200 in the same cycle as an ack, with queue holding 2 entries:
  - out_valid=0 next cycle.
  - next imem_addr is 0x200 and no stale entry is ever output.
- resetn pulsed low mid-stream with an outstanding request:
  - all outputs are 0 during reset.
  - after release, fetching restarts at RESET_PC with the first req one cycle later.
- With PIPE_FETCH_BYPASS_EN defined, empty queue, ack with rdata=0x2108000A:
  - out_valid=1 and out_inst=0x2108000A in the same cycle.
  - deq=1 in that cycle leaves count at 0.

Source files
------------

// File: rtl/pipe_fetch_pkg.sv
// Shared types for the instruction prefetch queue: FSM states, the queue entry
// layout and the datapath widths.
package pipe_fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus_4;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched entries with push, pop, flush and an occupancy count.
// Storage is not reset; only the pointers and the count are.
module fetch_queue_fifo
  import pipe_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction prefetch queue: one-outstanding imem handshake, DEPTH-entry buffer,
// redirect flush. Optional same-cycle bypass via `define PIPE_FETCH_BYPASS_EN.
module pipe_fetch_queue
  import pipe_fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              deq,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus_4,
  output logic [INST_W-1:0] out_inst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] fetch_pc_plus_4;
  logic [ADDR_W-1:0] redirect_pc_a;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     next_count;
  fetch_entry_t      q_head;
  fetch_entry_t      push_entry;
  logic              kept_ack;
  logic              deq_fire;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              bypass_hit;

  assign fetch_pc_plus_4 = fetch_pc + 32'd4;
  assign redirect_pc_a   = redirect_pc & ~32'h3;
  assign q_empty         = (q_count == '0);
  assign kept_ack        = (state == WAIT) & imem_ack & ~redirect;

`ifdef PIPE_FETCH_BYPASS_EN
  assign bypass_hit = q_empty & kept_ack;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid  = ~q_empty | bypass_hit;
  assign deq_fire   = deq & out_valid & ~redirect;
  // A bypassed word consumed in the same cycle never enters the buffer.
  assign push       = kept_ack & ~(bypass_hit & deq_fire);
  assign pop        = deq_fire & ~q_empty;
  assign next_count = q_count + CW'(kept_ack) - CW'(deq_fire);
  assign push_entry = '{pc: fetch_pc, pc_plus_4: fetch_pc_plus_4, inst: imem_rdata};

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (q_head),
    .count      (q_count)
  );

  always_comb begin
    out_pc        = '0;
    out_pc_plus_4 = '0;
    out_inst      = NOP_INST;
    if (bypass_hit) begin
      out_pc        = fetch_pc;
      out_pc_plus_4 = fetch_pc_plus_4;
      out_inst      = imem_rdata;
    end else if (!q_empty) begin
      out_pc        = q_head.pc;
      out_pc_plus_4 = q_head.pc_plus_4;
      out_inst      = q_head.inst;
    end
  end

  assign imem_addr = req_pc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      imem_req <= 1'b0;
      req_pc   <= '0;
      fetch_pc <= RESET_PC & ~32'h3;
    end else if (redirect) begin
      fetch_pc <= redirect_pc_a;
      case (state)
        IDLE: begin
          state    <= WAIT;
          imem_req <= 1'b1;
          req_pc   <= redirect_pc_a;
        end
        WAIT: begin
          if (imem_ack) req_pc <= redirect_pc_a;
          else          state  <= DISCARD;
        end
        DISCARD: ;
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (next_count < DEPTH_C) begin
            state    <= WAIT;
            imem_req <= 1'b1;
            req_pc   <= fetch_pc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc <= fetch_pc_plus_4;
            if (next_count < DEPTH_C) begin
              req_pc <= fetch_pc_plus_4;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // The stale word is dropped; fetch_pc already holds the redirect target.
          if (imem_ack) begin
            state  <= WAIT;
            req_pc <= fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue (DEPTH=4, RESET_PC=0); honours
// PIPE_FETCH_BYPASS_EN when defined for the build.
module tb_pipe_fetch_queue;

  logic        clock;
  logic        resetn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_inst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_cnt = 0;

  pipe_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .deq           (deq),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_inst      (out_inst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hE000_0000 ^ a;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Memory answers after lat_n idle request cycles (0 = same-cycle ack).
  task automatic mem_drive(input int lat_n);
    if (imem_req) begin
      if (lat_cnt >= lat_n) begin
        imem_ack   = 1'b1;
        imem_rdata = inst_of(imem_addr);
        lat_cnt    = 0;
      end else begin
        imem_ack = 1'b0;
        lat_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      lat_cnt  = 0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; lat_cnt = 0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; lat_cnt = 0;
    @(posedge clock); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_pc_plus_4 !== 32'h0) begin n_bad++; $display("FAIL rst_pc4: got %h want 0", out_pc_plus_4); end
    n_cmp++; if (out_inst !== 32'h0) begin n_bad++; $display("FAIL rst_inst: got %h want 0", out_inst); end
    imem_ack = 1'b0;
    resetn = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_rel_req: got %b want 0", imem_req); end
    next_cycle();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_first_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_zero_wait();
    logic        exp_v;
    logic [31:0] exp_pc;
    do_reset();
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      deq = 1'b1;
      mem_drive(0);
      #1;
`ifdef PIPE_FETCH_BYPASS_EN
      exp_v = 1'b1; exp_pc = 32'(4 * k);
`else
      exp_v = (k > 0); exp_pc = (k > 0) ? 32'(4 * (k - 1)) : 32'h0;
`endif
      n_cmp++; if (imem_addr !== 32'(4 * k)) begin n_bad++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * k)); end
      n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL zw_valid[%0d]: got %b want %b", k, out_valid, exp_v); end
      n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL zw_pc[%0d]: got %h want %h", k, out_pc, exp_pc); end
      if (exp_v) begin
        n_cmp++; if (out_pc_plus_4 !== exp_pc + 32'd4) begin n_bad++; $display("FAIL zw_pc4[%0d]: got %h want %h", k, out_pc_plus_4, exp_pc + 32'd4); end
        n_cmp++; if (out_inst !== inst_of(exp_pc)) begin n_bad++; $display("FAIL zw_inst[%0d]: got %h want %h", k, out_inst, inst_of(exp_pc)); end
      end
      next_cycle();
    end
    imem_ack = 1'b0; deq = 1'b0;
  endtask

  task automatic test_fill();
    int acks;
    int reqs;
    do_reset();
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      deq = 1'b0;
      mem_drive(0);
      #1;
      if (imem_ack) begin
        n_cmp++; if (imem_addr !== 32'(4 * acks)) begin n_bad++; $display("FAIL fill_addr[%0d]: got %h want %h", acks, imem_addr, 32'(4 * acks)); end
        acks++;
      end
    end
    imem_ack = 1'b0; #1;
    n_cmp++; if (acks !== 4) begin n_bad++; $display("FAIL fill_acks: got %0d want 4", acks); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL fill_req_low: got %b want 0", imem_req); end
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL fill_head: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
    deq = 1'b1; #1;
    next_cycle();
    deq = 1'b0; #1;
    n_cmp++; if (out_pc !== 32'h4) begin n_bad++; $display("FAIL fill_after_deq_pc: got %h want 4", out_pc); end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      mem_drive(0);
      #1;
      if (imem_ack) begin
        n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL refill_addr: got %h want 10", imem_addr); end
        reqs++;
      end
      next_cycle();
    end
    imem_ack = 1'b0; #1;
    n_cmp++; if (reqs !== 1) begin n_bad++; $display("FAIL refill_count: got %0d want 1", reqs); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL refill_req_low: got %b want 0", imem_req); end
  endtask

  task automatic test_redirect_discard();
    logic [31:0] ack_addr[$];
    logic [31:0] out_pcs[$];
    int stale;
    do_reset();
    for (int cyc = 0; cyc < 25; cyc++) begin
      next_cycle();
      deq = 1'b1;
      redirect = (cyc == 1);
      redirect_pc = 32'h100;
      mem_drive(2);
      #1;
      if (imem_ack) ack_addr.push_back(imem_addr);
      if (out_valid) out_pcs.push_back(out_pc);
    end
    redirect = 1'b0; imem_ack = 1'b0; deq = 1'b0;
    n_cmp++;
    if (ack_addr.size() < 3) begin n_bad++; $display("FAIL disc_acks: got %0d acks want >=3", ack_addr.size()); end
    else if (ack_addr[0] !== 32'h0 || ack_addr[1] !== 32'h100 || ack_addr[2] !== 32'h104) begin
      n_bad++; $display("FAIL disc_addr_seq: got %h %h %h want 0 100 104", ack_addr[0], ack_addr[1], ack_addr[2]);
    end
    n_cmp++;
    if (out_pcs.size() < 2) begin n_bad++; $display("FAIL disc_outs: got %0d outputs want >=2", out_pcs.size()); end
    else if (out_pcs[0] !== 32'h100 || out_pcs[1] !== 32'h104) begin
      n_bad++; $display("FAIL disc_out_seq: got %h %h want 100 104", out_pcs[0], out_pcs[1]);
    end
    stale = 0;
    foreach (out_pcs[i]) if (out_pcs[i] < 32'h100) stale++;
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL disc_stale: got %0d stale outputs want 0", stale); end
  endtask

  task automatic test_redirect_ack();
    logic [31:0] out_pcs[$];
    int stale;
    do_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      deq = 1'b0;
      mem_drive(0);
      redirect = (cyc == 2);
      redirect_pc = 32'h200;
      #1;
      if (cyc == 2) begin
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_bad++; $display("FAIL rda_pre: got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); end
      end
    end
    next_cycle();
    redirect = 1'b0; imem_ack = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rda_flush_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL rda_new_req: got req=%b addr=%h want req=1 addr=200", imem_req, imem_addr); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      next_cycle();
      deq = 1'b1;
      mem_drive(0);
      #1;
      if (out_valid) out_pcs.push_back(out_pc);
    end
    imem_ack = 1'b0; deq = 1'b0;
    n_cmp++;
    if (out_pcs.size() < 2) begin n_bad++; $display("FAIL rda_outs: got %0d outputs want >=2", out_pcs.size()); end
    else if (out_pcs[0] !== 32'h200 || out_pcs[1] !== 32'h204) begin
      n_bad++; $display("FAIL rda_out_seq: got %h %h want 200 204", out_pcs[0], out_pcs[1]);
    end
    stale = 0;
    foreach (out_pcs[i]) if (out_pcs[i] < 32'h200) stale++;
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL rda_stale: got %0d stale outputs want 0", stale); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      next_cycle();
      deq = 1'b1;
      mem_drive(0);
      #1;
    end
    next_cycle();
    mem_drive(2);
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_bad++; $display("FAIL mid_pre: got req=%b addr=%h want req=1 addr=c", imem_req, imem_addr); end
    resetn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_req: got req=%b addr=%h want 0 0", imem_req, imem_addr); end
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_pc_plus_4 !== 32'h0 || out_inst !== 32'h0) begin
      n_bad++; $display("FAIL mid_rst_out: got v=%b pc=%h pc4=%h inst=%h want all 0", out_valid, out_pc, out_pc_plus_4, out_inst);
    end
    next_cycle();
    n_cmp++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_hold: got req=%b v=%b want 0 0", imem_req, out_valid); end
    resetn = 1'b1; imem_ack = 1'b0; lat_cnt = 0; deq = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_rel_req: got %b want 0", imem_req); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      mem_drive(0);
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_bad++; $display("FAIL mid_restart[%0d]: got req=%b addr=%h want 1 %h", k, imem_req, imem_addr, 32'(4 * k)); end
      next_cycle();
    end
    imem_ack = 1'b0; deq = 1'b0;
  endtask

  task automatic test_ack_latency();
    do_reset();
    next_cycle();
    deq = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h2108_000A; #1;
`ifdef PIPE_FETCH_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'h2108_000A || out_pc !== 32'h0) begin
      n_bad++; $display("FAIL byp_same: got v=%b inst=%h pc=%h want 1 2108000a 0", out_valid, out_inst, out_pc);
    end
    next_cycle();
    imem_ack = 1'b0; deq = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL byp_consumed: got v=%b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL byp_next_addr: got %h want 4", imem_addr); end
`else
    n_cmp++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin n_bad++; $display("FAIL lat_same: got v=%b inst=%h want 0 0", out_valid, out_inst); end
    next_cycle();
    imem_ack = 1'b0; deq = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'h2108_000A) begin n_bad++; $display("FAIL lat_next: got v=%b inst=%h want 1 2108000a", out_valid, out_inst); end
    n_cmp++; if (out_pc !== 32'h0 || out_pc_plus_4 !== 32'h4) begin n_bad++; $display("FAIL lat_pc: got pc=%h pc4=%h want 0 4", out_pc, out_pc_plus_4); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_fill();
    test_redirect_discard();
    test_redirect_ack();
    test_reset_mid();
    test_ack_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
